// File: rtl/rnbip_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, default
// arbitration limits and a counter-width helper.
package rnbip_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int MAX_BURST_DEF    = 8;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dm_arb_counter.sv
// Small up-counter with clear priority; saturates or wraps at MAX_VAL.
// Used for both the DMA starvation count and the DMA burst beat count.
module dm_arb_counter #(
  parameter int WIDTH    = 3,
  parameter int MAX_VAL  = 7,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (count_q == WIDTH'(MAX_VAL)) begin
        count_d = SATURATE ? count_q : '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the stage-3 CPU port and a DMA loader/debug port,
// with CPU priority, starvation-forced DMA grants and bounded DMA tenures.
module dm_arbiter
  import rnbip_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int MAX_BURST    = MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_stall,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  input  logic       dma_last,
  output logic       dma_gnt,
  output logic       dma_rvalid,
  output logic [7:0] dma_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata
);

  localparam int SW = cnt_width(STARVE_LIMIT);
  localparam int BW = cnt_width(MAX_BURST - 1);

  arb_state_e state_q;
  arb_state_e state_d;

  logic          dma_rvalid_q;
  logic          dma_rvalid_d;
  logic [7:0]    dma_rdata_q;
  logic [7:0]    dma_rdata_d;

  logic          cpu_req;
  logic          own_cpu;
  logic          own_dma;
  logic          starved;
  logic          burst_end;
  logic          starve_inc;
  logic          starve_clr;
  logic          burst_clr;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;

  assign cpu_req = cpu_rd | cpu_wr;
  assign starved = (starve_cnt == SW'(STARVE_LIMIT));

  // Ownership, grant/stall and next state; reset overrides everything so the
  // memory sees no strobes and any tenure in flight is dropped.
  always_comb begin
    state_d   = state_q;
    own_cpu   = 1'b0;
    own_dma   = 1'b0;
    dma_gnt   = 1'b0;
    cpu_stall = 1'b0;
    burst_end = 1'b0;

    case (state_q)
      S_CPU: begin
        if (dma_req && (!cpu_req || starved)) begin
          own_dma   = 1'b1;
          dma_gnt   = 1'b1;
          cpu_stall = cpu_req;
        end else if (cpu_req) begin
          own_cpu = 1'b1;
        end
      end
      S_DMA: begin
        own_dma   = dma_req;
        dma_gnt   = dma_req;
        cpu_stall = cpu_req;
      end
      default: begin
        state_d = S_CPU;
      end
    endcase

    burst_end = dma_gnt && (dma_last || (burst_cnt == BW'(MAX_BURST - 1)));

    if ((state_q == S_DMA) && !dma_req) begin
      state_d = S_CPU;
    end else if (dma_gnt) begin
      state_d = burst_end ? S_CPU : S_DMA;
    end

    if (!rst_n) begin
      state_d   = S_CPU;
      own_cpu   = 1'b0;
      own_dma   = 1'b0;
      dma_gnt   = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  assign starve_inc = dma_req & ~dma_gnt;
  assign starve_clr = dma_gnt | ~dma_req;
  assign burst_clr  = (state_d == S_CPU);

  dm_arb_counter #(
    .WIDTH    (SW),
    .MAX_VAL  (STARVE_LIMIT),
    .SATURATE (1'b1)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (starve_clr),
    .inc   (starve_inc),
    .count (starve_cnt)
  );

  dm_arb_counter #(
    .WIDTH    (BW),
    .MAX_VAL  (MAX_BURST - 1),
    .SATURATE (1'b0)
  ) u_burst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (burst_clr),
    .inc   (dma_gnt),
    .count (burst_cnt)
  );

  // Memory port steering; a CPU read+write collapses to a write.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_rdata = 8'h00;
    if (own_dma) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
      mem_re    = ~dma_we;
    end else if (own_cpu) begin
      mem_we    = cpu_wr;
      mem_re    = cpu_rd & ~cpu_wr;
      cpu_rdata = mem_rdata;
    end
  end

  always_comb begin
    dma_rvalid_d = own_dma & ~dma_we;
    dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_CPU;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed vector table, burst/reset
// sequences, then randomized traffic against a behavioural arbitration model.
module tb_dm_arbiter;

  localparam int STARVE = 4;
  localparam int BURST  = 8;

  logic       clk;
  logic       rst_n;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       dma_req;
  logic       dma_we;
  logic [7:0] dma_addr;
  logic [7:0] dma_wdata;
  logic       dma_last;
  logic       dma_gnt;
  logic       dma_rvalid;
  logic [7:0] dma_rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;

  logic [7:0] tb_mem [256];

  int total;
  int bad;

  typedef struct {
    logic       rst_n;
    logic       rd;
    logic       wr;
    logic [7:0] ca;
    logic [7:0] cwd;
    logic       dq;
    logic       dwe;
    logic [7:0] da;
    logic [7:0] dwd;
    logic       dl;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic       gnt;
    logic       stall;
    logic       we;
    logic       re;
    logic       rv;
    logic [7:0] crd;
    logic [7:0] drd;
  } vec_t;

  dm_arbiter #(
    .STARVE_LIMIT (STARVE),
    .MAX_BURST    (BURST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_last   (dma_last),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the clock edge.
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
  end

  function automatic stim_t mk(input logic r, input logic rd, input logic wr,
                               input logic [7:0] ca, input logic [7:0] cwd,
                               input logic dq, input logic dwe,
                               input logic [7:0] da, input logic [7:0] dwd,
                               input logic dl);
    stim_t s;
    s.rst_n = r;  s.rd = rd;  s.wr = wr;  s.ca = ca;  s.cwd = cwd;
    s.dq = dq;    s.dwe = dwe; s.da = da; s.dwd = dwd; s.dl = dl;
    return s;
  endfunction

  function automatic vec_t row(input stim_t s, input logic g, input logic st,
                               input logic we, input logic re, input logic rv,
                               input logic [7:0] crd, input logic [7:0] drd);
    vec_t v;
    v.s = s; v.gnt = g; v.stall = st; v.we = we; v.re = re; v.rv = rv;
    v.crd = crd; v.drd = drd;
    return v;
  endfunction

  task automatic applyStimulus(input stim_t s);
    rst_n     = s.rst_n;
    cpu_rd    = s.rd;
    cpu_wr    = s.wr;
    cpu_addr  = s.ca;
    cpu_wdata = s.cwd;
    dma_req   = s.dq;
    dma_we    = s.dwe;
    dma_addr  = s.da;
    dma_wdata = s.dwd;
    dma_last  = s.dl;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic g, input logic st, input logic we,
                          input logic re, input logic rv, input logic [7:0] crd,
                          input logic [7:0] drd);
    checkOutput({tag, " dma_gnt"},    8'(dma_gnt),    8'(g));
    checkOutput({tag, " cpu_stall"},  8'(cpu_stall),  8'(st));
    checkOutput({tag, " mem_we"},     8'(mem_we),     8'(we));
    checkOutput({tag, " mem_re"},     8'(mem_re),     8'(re));
    checkOutput({tag, " dma_rvalid"}, 8'(dma_rvalid), 8'(rv));
    checkOutput({tag, " cpu_rdata"},  cpu_rdata,      crd);
    checkOutput({tag, " dma_rdata"},  dma_rdata,      drd);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state for the random phase.
  logic [7:0] model_mem [256];
  bit         m_tenure;
  int         m_beats;
  int         m_waited;
  bit         m_rv;
  logic [7:0] m_drd;

  vec_t vecs [13];
  int   grants;

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < 256; k++) tb_mem[k] = 8'h00;
    tb_mem[8'h20] = 8'h3C;
    for (int k = 0; k < 16; k++) tb_mem[8'h40 + k] = 8'(k + 1);
    tb_mem[8'h50] = 8'hC3;
    tb_mem[8'h51] = 8'hC4;

    applyStimulus(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0));
    nextCycle();
    nextCycle();

    //                   r    rd   wr   ca     cwd    dq   dwe  da     dwd    dl     g    st   we   re   rv   crd    drd
    vecs[0]  = row(mk(1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,1'b0,8'h20,8'h00,1'b0), 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    vecs[1]  = row(mk(1'b1,1'b0,1'b1,8'h10,8'hA5,1'b0,1'b0,8'h00,8'h00,1'b0), 1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,8'h00);
    vecs[2]  = row(mk(1'b1,1'b1,1'b0,8'h10,8'h00,1'b0,1'b0,8'h00,8'h00,1'b0), 1'b0,1'b0,1'b0,1'b1,1'b0,8'hA5,8'h00);
    vecs[3]  = row(mk(1'b1,1'b1,1'b1,8'h10,8'h5A,1'b0,1'b0,8'h00,8'h00,1'b0), 1'b0,1'b0,1'b1,1'b0,1'b0,8'hA5,8'h00);
    vecs[4]  = row(mk(1'b1,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h20,8'h00,1'b1), 1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,8'h00);
    vecs[5]  = row(mk(1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,8'h00,1'b0), 1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,8'h3C);
    vecs[6]  = row(mk(1'b1,1'b1,1'b0,8'h10,8'h00,1'b1,1'b1,8'h30,8'h77,1'b1), 1'b0,1'b0,1'b0,1'b1,1'b0,8'h5A,8'h3C);
    vecs[7]  = row(mk(1'b1,1'b1,1'b0,8'h10,8'h00,1'b1,1'b1,8'h30,8'h77,1'b1), 1'b0,1'b0,1'b0,1'b1,1'b0,8'h5A,8'h3C);
    vecs[8]  = row(mk(1'b1,1'b1,1'b0,8'h10,8'h00,1'b1,1'b1,8'h30,8'h77,1'b1), 1'b0,1'b0,1'b0,1'b1,1'b0,8'h5A,8'h3C);
    vecs[9]  = row(mk(1'b1,1'b1,1'b0,8'h10,8'h00,1'b1,1'b1,8'h30,8'h77,1'b1), 1'b0,1'b0,1'b0,1'b1,1'b0,8'h5A,8'h3C);
    vecs[10] = row(mk(1'b1,1'b1,1'b0,8'h10,8'h00,1'b1,1'b1,8'h30,8'h77,1'b1), 1'b1,1'b1,1'b1,1'b0,1'b0,8'h00,8'h3C);
    vecs[11] = row(mk(1'b1,1'b1,1'b0,8'h10,8'h00,1'b1,1'b1,8'h30,8'h77,1'b1), 1'b0,1'b0,1'b0,1'b1,1'b0,8'h5A,8'h3C);
    vecs[12] = row(mk(1'b1,1'b1,1'b0,8'h30,8'h00,1'b0,1'b0,8'h00,8'h00,1'b0), 1'b0,1'b0,1'b0,1'b1,1'b0,8'h77,8'h3C);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].s);
      @(negedge clk);
      checkAll($sformatf("row%0d", i), vecs[i].gnt, vecs[i].stall, vecs[i].we, vecs[i].re,
               vecs[i].rv, vecs[i].crd, vecs[i].drd);
      nextCycle();
    end

    // Endless burst (dma_last low) with the CPU joining after the first beat.
    grants = 0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(mk(1'b1, (i > 0), 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'(8'h40 + i), 8'h00, 1'b0));
      @(negedge clk);
      if (i < 12 && dma_gnt) grants++;
      checkOutput($sformatf("burst%0d dma_gnt", i), 8'(dma_gnt), 8'((i < 8) || (i == 12)));
      checkOutput($sformatf("burst%0d cpu_stall", i), 8'(cpu_stall), 8'(((i > 0) && (i < 8)) || (i == 12)));
      checkOutput($sformatf("burst%0d dma_rvalid", i), 8'(dma_rvalid), 8'((i >= 1) && (i <= 8)));
      checkOutput($sformatf("burst%0d dma_rdata", i), dma_rdata,
                  (i == 0) ? 8'h3C : ((i <= 8) ? 8'(i) : 8'h08));
      checkOutput($sformatf("burst%0d cpu_rdata", i), cpu_rdata,
                  ((i >= 8) && (i < 12)) ? 8'h5A : 8'h00);
      nextCycle();
    end
    checkOutput("burst grant count", 8'(grants), 8'(BURST));
    applyStimulus(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0));
    @(negedge clk);
    checkAll("burst_tail", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h0D);
    nextCycle();

    // Reset dropped on beat 3 of a read burst.
    applyStimulus(mk(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00, 1'b0));
    @(negedge clk);
    checkAll("rst_beat1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h0D);
    nextCycle();
    applyStimulus(mk(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h51, 8'h00, 1'b0));
    @(negedge clk);
    checkAll("rst_beat2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hC3);
    nextCycle();
    applyStimulus(mk(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h52, 8'h00, 1'b0));
    @(negedge clk);
    checkAll("rst_beat3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hC4);
    nextCycle();
    @(negedge clk);
    checkAll("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    nextCycle();
    applyStimulus(mk(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h52, 8'h00, 1'b0));
    @(negedge clk);
    checkAll("rst_release", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h00);
    nextCycle();
    applyStimulus(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0));
    @(negedge clk);
    checkAll("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    nextCycle();

    // Random traffic against the model.
    for (int k = 0; k < 256; k++) model_mem[k] = tb_mem[k];
    m_tenure = 1'b0;
    m_beats  = 0;
    m_waited = 0;
    m_rv     = 1'b0;
    m_drd    = 8'h00;
    begin
      stim_t s;
      bit    hold;
      hold = 1'b0;
      s = mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int c = 0; c < 400; c++) begin
        bit         creq;
        bit         e_gnt;
        bit         e_stall;
        bit         e_we;
        bit         e_re;
        int         owner;
        logic [7:0] e_crd;
        logic [7:0] e_addr;

        s.rst_n = ($urandom_range(0, 40) != 0);
        if (!hold) begin
          s.rd  = $urandom_range(0, 1);
          s.wr  = ($urandom_range(0, 2) == 0);
          s.ca  = 8'($urandom_range(0, 15));
          s.cwd = 8'($urandom);
        end
        s.dq  = ($urandom_range(0, 3) != 0);
        s.dwe = $urandom_range(0, 1);
        s.da  = 8'($urandom_range(0, 15));
        s.dwd = 8'($urandom);
        s.dl  = ($urandom_range(0, 7) == 0);
        applyStimulus(s);

        creq    = s.rd | s.wr;
        owner   = 0;
        e_gnt   = 1'b0;
        e_stall = 1'b0;
        if (s.rst_n) begin
          if (!m_tenure) begin
            if (s.dq && (!creq || m_waited >= STARVE)) begin
              owner = 2; e_gnt = 1'b1; e_stall = creq;
            end else if (creq) begin
              owner = 1;
            end
          end else begin
            e_gnt = s.dq; e_stall = creq;
            if (s.dq) owner = 2;
          end
        end
        e_we   = (owner == 2) ? s.dwe : ((owner == 1) ? s.wr : 1'b0);
        e_re   = (owner == 2) ? ~s.dwe : ((owner == 1) ? (s.rd & ~s.wr) : 1'b0);
        e_addr = (owner == 2) ? s.da : s.ca;
        e_crd  = (owner == 1) ? model_mem[s.ca] : 8'h00;

        @(negedge clk);
        checkAll($sformatf("rand%0d", c), e_gnt, e_stall, e_we, e_re, m_rv, e_crd, m_drd);
        if (owner != 0) checkOutput($sformatf("rand%0d mem_addr", c), mem_addr, e_addr);

        if (!s.rst_n) begin
          m_tenure = 1'b0; m_beats = 0; m_waited = 0; m_rv = 1'b0; m_drd = 8'h00;
        end else begin
          m_rv = (owner == 2) && !s.dwe;
          if (m_rv) m_drd = model_mem[s.da];
          if (owner == 1 && s.wr) model_mem[s.ca] = s.cwd;
          if (owner == 2 && s.dwe) model_mem[s.da] = s.dwd;
          if (e_gnt) begin
            m_beats++;
            if (s.dl || m_beats == BURST) begin
              m_tenure = 1'b0; m_beats = 0;
            end else begin
              m_tenure = 1'b1;
            end
          end else if (m_tenure) begin
            m_tenure = 1'b0; m_beats = 0;
          end
          if (s.dq && !e_gnt) m_waited = (m_waited < STARVE) ? m_waited + 1 : STARVE;
          else m_waited = 0;
        end
        hold = e_stall;
        nextCycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied DMA cycles before the CPU is forcibly stalled.
REQ-002 SHALL have parameter MAX_BURST, default 8, meaning the maximum beats per DMA tenure.
REQ-003 SHALL have ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  synchronous active-low reset.
- cpu_rd  in  1  stage-3 data-memory read request.
- cpu_wr  in  1  stage-3 data-memory write request.
- cpu_addr  in  8  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data.
- cpu_stall  out  1  holds all pipeline stages when high.
- dma_req  in  1  loader/debug port request.
- dma_we  in  1  DMA write (1) or read (0).
- dma_addr  in  8  DMA address.
- dma_wdata  in  8  DMA write data.
- dma_last  in  1  marks the final beat of a burst.
- dma_gnt  out  1  current DMA beat accepted.
- dma_rvalid  out  1  dma_rdata valid.
- dma_rdata  out  8  DMA read data.
- mem_addr  out  8  to data memory.
- mem_wdata  out  8  to data memory.
- mem_we  out  1  to data memory.
- mem_re  out  1  to data memory.
- mem_rdata  in  8  combinational read data from data memory.

Function
REQ-004 SHALL give the memory port to exactly one owner per cycle; mem_we/mem_re SHALL both be 0 when no request is granted.
REQ-005 SHALL implement states S_CPU (CPU priority) and S_DMA (DMA tenure), encoded 1 bit.
REQ-006 In S_CPU, if cpu_rd|cpu_wr is high and starve_cnt<STARVE_LIMIT, CPU SHALL own the port: cpu_stall=0, dma_gnt=0.
REQ-007 In S_CPU, if dma_req is high and either no CPU request is present or starve_cnt==STARVE_LIMIT, DMA SHALL own the port, dma_gnt=1, cpu_stall=(cpu_rd|cpu_wr), and the next state SHALL be S_DMA unless that beat ends the tenure (REQ-009).
REQ-008 In S_DMA, dma_gnt SHALL equal dma_req, and cpu_stall SHALL equal (cpu_rd|cpu_wr).
REQ-009 The DMA tenure SHALL end (next state S_CPU) after:
- a granted beat with dma_last=1, or
- a cycle with dma_req=0, or
- the granted beat where burst_cnt==MAX_BURST-1.
REQ-010 burst_cnt (3 bits for the default) SHALL clear on entry to S_CPU and increment per granted beat in S_DMA.
REQ-011 starve_cnt SHALL increment on each cycle with dma_req=1 and dma_gnt=0, saturate at STARVE_LIMIT, and clear on any grant or when dma_req=0.
REQ-012 CPU ownership SHALL produce:
- mem_addr=cpu_addr and mem_wdata=cpu_wdata.
- mem_we=cpu_wr and mem_re=cpu_rd&~cpu_wr; write wins if both are asserted.
- cpu_rdata=mem_rdata, combinational and zero-latency.
REQ-013 DMA ownership SHALL produce mem_addr=dma_addr, mem_wdata=dma_wdata, mem_we=dma_we, and mem_re=~dma_we.
REQ-014 A granted DMA read SHALL register mem_rdata into dma_rdata and pulse dma_rvalid for exactly one cycle, 1 cycle after the grant.
REQ-015 dma_rdata SHALL hold its value until the next granted read.
REQ-016 cpu_rdata SHALL be 8'h00 whenever the CPU does not own the port.
REQ-017 A stalled CPU request SHALL NOT be lost: it SHALL be serviced on the first non-stall cycle while the pipeline holds cpu_* stable.

Reset
REQ-018 On rst_n=0 at a clk edge:
- state SHALL become S_CPU.
- starve_cnt and burst_cnt SHALL become 0.
- dma_rvalid and dma_rdata SHALL become 0.
REQ-019 While rst_n=0, dma_gnt, cpu_stall, mem_we and mem_re SHALL be forced to 0.
REQ-020 A reset asserted mid-burst SHALL abort the tenure; no dma_rvalid pulse SHALL follow.

Structure
REQ-021 The state encoding and the default STARVE_LIMIT/MAX_BURST constants SHALL live in the shared package rnbip_pkg.
REQ-022 The starvation and burst counters SHALL be one sub-module, dm_arb_counter, instantiated twice with saturate/wrap modes.

Verification
REQ-023 The bench SHALL cover:
- CPU-only traffic, cpu_wr to 8'h10 with wdata 8'hA5, then cpu_rd from 8'h10 -> mem_we=1 in the first cycle; cpu_rdata=8'hA5 in the second; cpu_stall stays 0.
- DMA-only read from 8'h20 with the memory holding 8'h3C -> dma_gnt=1 in the same cycle; dma_rvalid=1 and dma_rdata=8'h3C in the next cycle.
- CPU requesting continuously while dma_req is held -> DMA is denied for 4 cycles, then granted in the 5th with cpu_stall=1; a single beat with dma_last=1 returns the port to the CPU in the 6th.
- 12-beat DMA burst with dma_last never asserted -> exactly 8 grants, then S_CPU, starve_cnt restarting from 0.
- rst_n dropped during beat 3 of a read burst -> the next cycle shows dma_gnt=0, dma_rvalid=0 and cpu_stall=0; the state is S_CPU.
- cpu_rd and cpu_wr both high -> mem_we=1, mem_re=0.
